// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// Accepted accesses flow through a 3-stage pipeline that returns a completion pulse to the originator.
module sram_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_wmask_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_wmask_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            o_csb0,
  output logic            o_web0,
  output logic [AW-1:0]   o_waddr0,
  output logic [DW-1:0]   o_din0,
  output logic [DW/8-1:0] o_wmask0,
  input  logic [DW-1:0]   i_dout0,
  input  logic            clr_i,
  output logic [15:0]     conflict_cnt_o
);

  // Handshake: an access is accepted in any cycle where req && gnt; while gnt is
  // low the requester may hold, change or drop its request freely.
  logic            prio;  // 0: m0 wins a tie, 1: m1 wins a tie
  logic            grant;
  logic            gnt_id;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wmask;

  logic s1_valid, s1_id, s1_we;
  logic s2_valid, s2_id, s2_we;

  assign m0_gnt_o  = rst_ni & m0_req_i & (~m1_req_i | ~prio);
  assign m1_gnt_o  = rst_ni & m1_req_i & (~m0_req_i |  prio);
  assign grant     = m0_gnt_o | m1_gnt_o;
  assign gnt_id    = m1_gnt_o;
  assign sel_we    = gnt_id ? m1_we_i    : m0_we_i;
  assign sel_addr  = gnt_id ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = gnt_id ? m1_wdata_i : m0_wdata_i;
  assign sel_wmask = gnt_id ? m1_wmask_i : m0_wmask_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio           <= 1'b0;
      o_csb0         <= 1'b1;
      o_web0         <= 1'b1;
      o_waddr0       <= '0;
      o_din0         <= '0;
      o_wmask0       <= '0;
      s1_valid       <= 1'b0;
      s1_id          <= 1'b0;
      s1_we          <= 1'b0;
      s2_valid       <= 1'b0;
      s2_id          <= 1'b0;
      s2_we          <= 1'b0;
      m0_rvalid_o    <= 1'b0;
      m1_rvalid_o    <= 1'b0;
      m0_rdata_o     <= '0;
      m1_rdata_o     <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (grant) begin
        prio     <= ~gnt_id;
        o_waddr0 <= sel_addr;
        o_din0   <= sel_wdata;
        o_wmask0 <= sel_we ? sel_wmask : '0;
      end
      o_csb0 <= ~grant;
      o_web0 <= ~(grant & sel_we);

      s1_valid <= grant;
      s1_id    <= gnt_id;
      s1_we    <= sel_we;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_we    <= s1_we;

      // SRAM read data is present during stage 2; writes complete with zero data.
      m0_rvalid_o <= s2_valid & ~s2_id;
      m1_rvalid_o <= s2_valid &  s2_id;
      m0_rdata_o  <= (s2_valid & ~s2_id & ~s2_we) ? i_dout0 : '0;
      m1_rdata_o  <= (s2_valid &  s2_id & ~s2_we) ? i_dout0 : '0;

      if (clr_i) begin
        conflict_cnt_o <= '0;
      end else if (m0_req_i && m1_req_i && conflict_cnt_o != 16'hFFFF) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end

endmodule
